// File: rtl/stepgen_timed.sv
// Step/direction generator with enable, minimum STP pulse width and DIR setup time.
// Feedback step counter is present only when STEPGEN_FEEDBACK_EN is defined; otherwise jointFeedback is 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | not stepping; every cycle is a decision point
// DIR_WAIT | DIR just changed; holding STP low for DIR_SETUP clocks
// HIGH     | STP high for PULSE_WIDTH clocks
// LOW      | STP low for max(P - PULSE_WIDTH, PULSE_WIDTH); last cycle decides
module stepgen_timed #(
    parameter int WIDTH       = 32,
    parameter int PULSE_WIDTH = 48,
    parameter int DIR_SETUP   = 96
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] jointFreqCmd,
    output logic signed [WIDTH-1:0] jointFeedback,
    output logic                    DIR,
    output logic                    STP
);

    localparam int PW_W      = $clog2(PULSE_WIDTH + 1);
    localparam int DS_W      = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;
    localparam int DS_LAST_I = (DIR_SETUP > 0) ? DIR_SETUP - 1 : 0;

    localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PULSE_WIDTH - 1);
    localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);
    localparam logic [DS_W-1:0]  DS_LAST = DS_W'(DS_LAST_I);
    localparam logic [DS_W-1:0]  DS_ONE  = DS_W'(1);
    localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   X_ONE   = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   PW_EXT  = (WIDTH + 1)'(PULSE_WIDTH);
    localparam logic [WIDTH:0]   TWO_PW  = (WIDTH + 1)'(2 * PULSE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIR_WAIT = 2'd1,
        S_HIGH     = 2'd2,
        S_LOW      = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dir;
    logic             r_stp;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_low_cnt;
    logic [PW_W-1:0]  r_pulse_cnt;
    logic [DS_W-1:0]  r_setup_cnt;

    logic             w_dir_nxt;
    logic             w_dir_req;
    logic             w_decide;
    logic             w_latch;
    logic             w_enter_high;
    logic             w_enter_wait;
    logic             w_enter_low;
    logic [WIDTH-1:0] w_cmd_abs;
    logic [WIDTH:0]   w_period_ext;
    logic [WIDTH-1:0] w_low_last;

    // Two's-complement magnitude; the most negative command maps to 2^(WIDTH-1).
    assign w_cmd_abs = jointFreqCmd[WIDTH-1] ? WIDTH'(-jointFreqCmd) : WIDTH'(jointFreqCmd);
    assign w_dir_req = ~jointFreqCmd[WIDTH-1];

    always_comb begin
        w_period_ext = {1'b0, r_period};
        if (w_period_ext >= TWO_PW) begin
            w_low_last = WIDTH'(w_period_ext - PW_EXT - X_ONE);
        end else begin
            w_low_last = WIDTH'(PW_EXT - X_ONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_decide    = 1'b0;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_decide = 1'b1;
            end
            S_DIR_WAIT: begin
                if (r_setup_cnt == '0) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_pulse_cnt == '0) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (r_low_cnt == '0) begin
                    w_decide = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Command is sampled only here, so the period and direction stay consistent
        // through any DIR_WAIT that follows.
        if (w_decide) begin
            if (!enable || (jointFreqCmd == '0)) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_latch = 1'b1;
                if (w_dir_req != r_dir) begin
                    w_dir_nxt = w_dir_req;
                    if (DIR_SETUP == 0) begin
                        w_state_nxt = S_HIGH;
                    end else begin
                        w_state_nxt = S_DIR_WAIT;
                    end
                end else begin
                    w_state_nxt = S_HIGH;
                end
            end
        end
    end

    assign w_enter_high = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);
    assign w_enter_wait = (w_state_nxt == S_DIR_WAIT) && (r_state != S_DIR_WAIT);
    assign w_enter_low  = (w_state_nxt == S_LOW) && (r_state == S_HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_stp   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_stp   <= (w_state_nxt == S_HIGH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
        end else if (w_latch) begin
            r_period <= w_cmd_abs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= '0;
        end else if (w_enter_high) begin
            r_pulse_cnt <= PW_LAST;
        end else if ((r_state == S_HIGH) && (r_pulse_cnt != '0)) begin
            r_pulse_cnt <= r_pulse_cnt - PW_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_setup_cnt <= '0;
        end else if (w_enter_wait) begin
            r_setup_cnt <= DS_LAST;
        end else if ((r_state == S_DIR_WAIT) && (r_setup_cnt != '0)) begin
            r_setup_cnt <= r_setup_cnt - DS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= '0;
        end else if (w_enter_low) begin
            r_low_cnt <= w_low_last;
        end else if ((r_state == S_LOW) && (r_low_cnt != '0)) begin
            r_low_cnt <= r_low_cnt - W_ONE;
        end
    end

`ifdef STEPGEN_FEEDBACK_EN
    logic [WIDTH-1:0] r_feedback;

    // Counts on the same edge STP rises, using the direction in force for that step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feedback <= '0;
        end else if (w_enter_high) begin
            if (w_dir_nxt) begin
                r_feedback <= r_feedback + W_ONE;
            end else begin
                r_feedback <= r_feedback - W_ONE;
            end
        end
    end

    assign jointFeedback = r_feedback;
`else
    assign jointFeedback = '0;
`endif

    assign DIR = r_dir;
    assign STP = r_stp;

endmodule

// File: tb/tb_stepgen_timed.sv
// Directed + randomized bench for stepgen_timed; expected edge times come from
// period/low-time arithmetic and a step-count model, not from the FSM structure.
module tb_stepgen_timed;

    localparam int W  = 32;
    localparam int PW = 100;
    localparam int DS = 50;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic signed [W-1:0] cmd;
    logic signed [W-1:0] fb;
    logic                dir;
    logic                stp;

    logic                rst_w_n;
    logic                en_w;
    logic signed [7:0]   cmd_w;
    logic signed [7:0]   fb_w;
    logic                dir_w;
    logic                stp_w;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    int cur_cmd = 0;
    bit m_dir = 1'b0;
    int m_fb = 0;
    int t_last = 0;

    stepgen_timed #(.WIDTH(W), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .jointFreqCmd(cmd),
        .jointFeedback(fb), .DIR(dir), .STP(stp)
    );

    stepgen_timed #(.WIDTH(8), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) u_wrap (
        .clk(clk), .rst_n(rst_w_n), .enable(en_w), .jointFreqCmd(cmd_w),
        .jointFeedback(fb_w), .DIR(dir_w), .STP(stp_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int period_of(input int c);
        int a;
        a = (c < 0) ? -c : c;
        return (a > 2 * PW) ? a : 2 * PW;
    endfunction

    function automatic logic [W-1:0] fb_exp(input int m);
`ifdef STEPGEN_FEEDBACK_EN
        return W'(m);
`else
        return '0;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // which: 0 = STP rise, 1 = STP fall, 2 = DIR change; sampled on falling clock edges
    task automatic wait_ev(input int which, input int budget, output int t, output bit ok);
        logic prev;
        logic cur;
        prev = (which == 2) ? dir : stp;
        ok = 1'b0;
        t = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = (which == 2) ? dir : stp;
            if ((which == 0 && cur && !prev) || (which == 1 && !cur && prev) ||
                (which == 2 && cur !== prev)) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
            prev = cur;
        end
    endtask

    // Start from IDLE: decision on the next clock edge.
    task automatic start(input int nc);
        int t0;
        int t;
        bit ok;
        bit ndir;
        int t_exp;
        ndir = (nc > 0);
        cmd = W'(nc);
        enable = 1'b1;
        t0 = cyc;
        t_exp = t0 + 1;
        if (ndir != m_dir) begin
            t_exp += DS;
            @(negedge clk);
            check("dir_early", dir, ndir);
            check("stp_low_in_setup", stp, 0);
        end
        wait_ev(0, DS + 10, t, ok);
        check("start_rise_seen", ok, 1);
        check("start_rise_time", t, t_exp);
        m_dir = ndir;
        m_fb += ndir ? 1 : -1;
        cur_cmd = nc;
        t_last = t;
        check("start_dir", dir, ndir);
        check("start_feedback", fb, fb_exp(m_fb));
    endtask

    // Called on the sample right after a rise; the new command takes effect at the next decision.
    task automatic step(input int nc);
        int t;
        bit ok;
        int per;
        bit ndir;
        int t_exp;
        per = period_of(cur_cmd);
        ndir = (nc > 0);
        cmd = W'(nc);
        wait_ev(1, PW + 5, t, ok);
        check("fall_seen", ok, 1);
        check("high_width", t - t_last, PW);
        t_exp = t_last + per;
        if (ndir != m_dir) begin
            wait_ev(2, per + 5, t, ok);
            check("dir_change_seen", ok, 1);
            check("dir_change_time", t, t_exp);
            check("stp_low_at_dir", stp, 0);
            t_exp += DS;
        end
        wait_ev(0, per + DS + 5, t, ok);
        check("rise_seen", ok, 1);
        check("rise_time", t, t_exp);
        m_dir = ndir;
        m_fb += ndir ? 1 : -1;
        cur_cmd = nc;
        t_last = t;
        check("dir", dir, ndir);
        check("feedback", fb, fb_exp(m_fb));
    endtask

    task automatic stop_mid(input bit use_enable);
        int t;
        bit ok;
        repeat (10) @(negedge clk);
        if (use_enable) enable = 1'b0;
        else cmd = '0;
        wait_ev(1, PW, t, ok);
        check("stop_fall_seen", ok, 1);
        check("stop_high_width", t - t_last, PW);
        wait_ev(0, 1500, t, ok);
        check("stop_no_rise", ok, 0);
        check("stop_feedback", fb, fb_exp(m_fb));
        check("stop_stp", stp, 0);
        check("stop_dir", dir, m_dir);
    endtask

    initial begin
        int mag;
        int nc;
        int k;
        logic prev_w;
        logic [7:0] exp8;

        rst_n = 1'b0;
        rst_w_n = 1'b0;
        enable = 1'b0;
        cmd = '0;
        en_w = 1'b0;
        cmd_w = '0;
        repeat (3) @(negedge clk);
        check("rst_stp", stp, 0);
        check("rst_dir", dir, 0);
        check("rst_fb", fb, 0);
        rst_n = 1'b1;
        rst_w_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stp", stp, 0);

        // positive run: 10 rises at 1000
        start(1000);
        for (int i = 0; i < 9; i++) step(1000);
        check("ten_steps_fb", fb, fb_exp(10));

        // period clamp to 2*PW
        step(10);
        step(10);
        step(10);

        // random commands, magnitudes spanning the clamp, random signs
        for (int i = 0; i < 8; i++) begin
            mag = int'($urandom_range(1, 700));
            nc = ($urandom_range(0, 1) == 1) ? -mag : mag;
            step(nc);
        end

        // directed reversal issued mid-HIGH
        step(1000);
        step(1000);
        step(-1000);
        step(-1000);

        // stop via enable, restart without DIR change, stop via cmd=0
        stop_mid(1'b1);
        start(-1000);
        stop_mid(1'b0);

        // async reset mid-HIGH, then restart requiring DIR setup
        start(1000);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_stp", stp, 0);
        check("async_dir", dir, 0);
        check("async_fb", fb, 0);
        m_dir = 1'b0;
        m_fb = 0;
        #2 rst_n = 1'b1;
        start(1000);
        step(1000);

        // 8-bit feedback wrap on the 128th positive step
        en_w = 1'b1;
        cmd_w = 8'sd100;
        k = 0;
        prev_w = stp_w;
        for (int i = 0; i < 30000 && k < 128; i++) begin
            @(negedge clk);
            if (stp_w && !prev_w) begin
                k++;
                if (k == 127 || k == 128) begin
`ifdef STEPGEN_FEEDBACK_EN
                    exp8 = 8'(k);
`else
                    exp8 = 8'd0;
`endif
                    check((k == 127) ? "wrap_127" : "wrap_128", {24'd0, fb_w}, {24'd0, exp8});
                end
            end
            prev_w = stp_w;
        end
        check("wrap_steps", k, 128);
        check("wrap_dir", dir_w, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
